insn_fetch_ctrl: RTL and testbench

//   Fetch sequencer in front of insn_decoder. Owns the program counter and

---
 rtl/insn_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_insn_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem read at a time and buffers
// returned words in a 2-entry FIFO facing the decoder. Handles redirect and halt.
module insn_fetch_ctrl #(
    parameter int LEN_INSN = 32,
    parameter int LEN_PC   = 16,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [LEN_PC-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [LEN_INSN-1:0] imem_data,
    output logic                dec_valid,
    output logic [LEN_INSN-1:0] dec_insn,
    output logic [LEN_PC-1:0]   dec_pc,
    input  logic                dec_ready,
    input  logic                redirect,
    input  logic [LEN_PC-1:0]   redirect_pc,
    input  logic                halt,
    output logic                halted
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DISCARD,
        S_HALT
    } state_t;

    state_t              state, state_d;
    logic [LEN_PC-1:0]   pc, pc_d, addr_d;
    logic                req_d;
    logic                push;
    logic                pop;
    logic                xfer;
    logic [1:0]          count, count_d;
    logic [LEN_INSN-1:0] insn0, insn1;
    logic [LEN_PC-1:0]   pc0, pc1;

    assign xfer     = imem_req & imem_ack;
    assign pop      = dec_valid & dec_ready;
    assign dec_insn = insn0;
    assign dec_pc   = pc0;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        req_d   = imem_req;
        addr_d  = imem_addr;
        push    = 1'b0;
        case (state)
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (count < 2'd2 && !redirect) begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (xfer) begin
                    req_d   = 1'b0;
                    state_d = S_RUN;
                    // A redirect on the ack edge kills the returning word.
                    if (!redirect) begin
                        push = 1'b1;
                        pc_d = pc + LEN_PC'(1);
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (xfer) begin
                    req_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                if (!halt) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        if (redirect) pc_d = redirect_pc;
        if (redirect) count_d = 2'd0;
        else          count_d = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            pc        <= LEN_PC'(RESET_PC);
            imem_req  <= 1'b0;
            imem_addr <= '0;
            halted    <= 1'b0;
            count     <= 2'd0;
            dec_valid <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            halted    <= (state_d == S_HALT);
            count     <= count_d;
            dec_valid <= (count_d != 2'd0);
        end
    end

    // FIFO storage: entry 0 is the head seen by the decoder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            insn0 <= '0;
            pc0   <= '0;
            insn1 <= '0;
            pc1   <= '0;
        end else if (!redirect) begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        insn0 <= imem_data;
                        pc0   <= imem_addr;
                    end else begin
                        insn1 <= imem_data;
                        pc1   <= imem_addr;
                    end
                end
                2'b01: begin
                    insn0 <= insn1;
                    pc0   <= pc1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        insn0 <= imem_data;
                        pc0   <= imem_addr;
                    end else begin
                        insn0 <= insn1;
                        pc0   <= pc1;
                        insn1 <= imem_data;
                        pc1   <= imem_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_insn_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        dec_valid;
    logic [31:0] dec_insn;
    logic [15:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] insn;
        logic [15:0] pc;
    } word_t;

    // Reference model state
    word_t       mq[$];
    logic [15:0] mpc;
    logic [15:0] m_addr;
    bit          m_inflight;
    bit          m_keep;
    bit          m_halted;

    insn_fetch_ctrl #(.LEN_INSN(32), .LEN_PC(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .dec_valid(dec_valid), .dec_insn(dec_insn), .dec_pc(dec_pc),
        .dec_ready(dec_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mpc        = 16'h0000;
        m_addr     = 16'h0000;
        m_inflight = 0;
        m_keep     = 0;
        m_halted   = 0;
    endtask

    // One clock: advance the model on the rising edge, return at the falling edge.
    task automatic step();
        int    sz;
        word_t w;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            sz = mq.size();
            if (sz != 0 && dec_ready) void'(mq.pop_front());
            if (m_inflight) begin
                if (imem_ack) begin
                    if (m_keep && !redirect) begin
                        w.insn = imem_data;
                        w.pc   = m_addr;
                        mq.push_back(w);
                        mpc = mpc + 16'd1;
                    end
                    m_inflight = 0;
                end else if (redirect) begin
                    m_keep = 0;
                end
            end else if (m_halted) begin
                if (!halt) m_halted = 0;
            end else if (halt) begin
                m_halted = 1;
            end else if (sz < 2 && !redirect) begin
                m_inflight = 1;
                m_keep     = 1;
                m_addr     = mpc;
            end
            if (redirect) begin
                mpc = redirect_pc;
                mq.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; imem_ack = 1'b0; imem_data = '0; dec_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        step();
        tests++; if (imem_req !== 1'b0)   begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        tests++; if (dec_valid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
        tests++; if (dec_insn !== 32'h0)  begin fails++; $display("FAIL reset_insn: got %h want 0", dec_insn); end
        tests++; if (dec_pc !== 16'h0)    begin fails++; $display("FAIL reset_pc: got %h want 0", dec_pc); end
        tests++; if (halted !== 1'b0)     begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
        rst = 1'b1;
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr); end
    endtask

    task automatic test_basic();
        do_reset();
        dec_ready = 1'b1;
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL basic_req0: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = 32'h04125555;
        step();
        imem_ack = 1'b0;
        tests++; if ({dec_valid, dec_insn, dec_pc} !== {1'b1, 32'h04125555, 16'h0000}) begin fails++; $display("FAIL basic_dec0: got v=%b insn=%h pc=%h want 1/04125555/0000", dec_valid, dec_insn, dec_pc); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_gap: got req=%b want 0", imem_req); end
        step();
        tests++; if ({imem_req, imem_addr, dec_valid} !== {1'b1, 16'h0001, 1'b0}) begin fails++; $display("FAIL basic_req1: got req=%b addr=%h v=%b want 1/0001/0", imem_req, imem_addr, dec_valid); end
        imem_ack = 1'b1; imem_data = 32'h0412FFFF;
        step();
        imem_ack = 1'b0;
        tests++; if ({dec_valid, dec_insn, dec_pc} !== {1'b1, 32'h0412FFFF, 16'h0001}) begin fails++; $display("FAIL basic_dec1: got v=%b insn=%h pc=%h want 1/0412ffff/0001", dec_valid, dec_insn, dec_pc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        a = $urandom(); b = $urandom();
        do_reset();
        step();
        imem_ack = 1'b1; imem_data = a;
        step();
        imem_ack = 1'b0;
        tests++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid: got %b want 1", dec_valid); end
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL bp_req1: got req=%b addr=%h want 1/0001", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = b;
        step();
        imem_ack = 1'b0;
        step();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_full_noreq: got %b want 0", imem_req); end
        step();
        tests++; if ({imem_req, dec_valid, dec_insn, dec_pc} !== {1'b0, 1'b1, a, 16'h0000}) begin fails++; $display("FAIL bp_head_a: got req=%b v=%b insn=%h pc=%h want 0/1/%h/0000", imem_req, dec_valid, dec_insn, dec_pc, a); end
        dec_ready = 1'b1;
        step();
        tests++; if ({imem_req, dec_valid, dec_insn, dec_pc} !== {1'b0, 1'b1, b, 16'h0001}) begin fails++; $display("FAIL bp_head_b: got req=%b v=%b insn=%h pc=%h want 0/1/%h/0001", imem_req, dec_valid, dec_insn, dec_pc, b); end
        step();
        tests++; if ({imem_req, imem_addr, dec_valid} !== {1'b1, 16'h0002, 1'b0}) begin fails++; $display("FAIL bp_resume: got req=%b addr=%h v=%b want 1/0002/0", imem_req, imem_addr, dec_valid); end
    endtask

    task automatic test_redirect_wait();
        int seen;
        do_reset();
        dec_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0005;
        step();
        redirect = 1'b0;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rdw_nolaunch: got %b want 0", imem_req); end
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0005}) begin fails++; $display("FAIL rdw_req5: got req=%b addr=%h want 1/0005", imem_req, imem_addr); end
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0005}) begin fails++; $display("FAIL rdw_held: got req=%b addr=%h want 1/0005", imem_req, imem_addr); end
        seen = 0;
        step(); seen += int'(dec_valid);
        step(); seen += int'(dec_valid);
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
        step(); seen += int'(dec_valid);
        imem_ack = 1'b0;
        tests++; if ({seen, imem_req} !== {32'd0, 1'b0}) begin fails++; $display("FAIL rdw_dropped: got valid_cycles=%0d req=%b want 0/0", seen, imem_req); end
        step();
        tests++; if ({imem_req, imem_addr, dec_valid} !== {1'b1, 16'h0100, 1'b0}) begin fails++; $display("FAIL rdw_refetch: got req=%b addr=%h v=%b want 1/0100/0", imem_req, imem_addr, dec_valid); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        dec_ready = 1'b1;
        step();
        imem_ack = 1'b1; imem_data = $urandom(); redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        imem_ack = 1'b0; redirect = 1'b0;
        tests++; if ({dec_valid, imem_req} !== 2'b00) begin fails++; $display("FAIL rda_dropped: got v=%b req=%b want 0/0", dec_valid, imem_req); end
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0200}) begin fails++; $display("FAIL rda_refetch: got req=%b addr=%h want 1/0200", imem_req, imem_addr); end
    endtask

    task automatic test_halt();
        logic [31:0] d;
        d = $urandom();
        do_reset();
        step();
        halt = 1'b1;
        step();
        tests++; if ({imem_req, halted} !== 2'b10) begin fails++; $display("FAIL halt_inflight: got req=%b halted=%b want 1/0", imem_req, halted); end
        imem_ack = 1'b1; imem_data = d;
        step();
        imem_ack = 1'b0;
        tests++; if ({dec_valid, dec_insn, imem_req, halted} !== {1'b1, d, 1'b0, 1'b0}) begin fails++; $display("FAIL halt_pushed: got v=%b insn=%h req=%b halted=%b want 1/%h/0/0", dec_valid, dec_insn, imem_req, halted, d); end
        step();
        tests++; if ({halted, imem_req} !== 2'b10) begin fails++; $display("FAIL halt_enter: got halted=%b req=%b want 1/0", halted, imem_req); end
        step();
        tests++; if ({halted, imem_req, dec_valid} !== 3'b101) begin fails++; $display("FAIL halt_stay: got halted=%b req=%b v=%b want 1/0/1", halted, imem_req, dec_valid); end
        dec_ready = 1'b1;
        step();
        tests++; if ({dec_valid, halted} !== 2'b01) begin fails++; $display("FAIL halt_drain: got v=%b halted=%b want 0/1", dec_valid, halted); end
        halt = 1'b0; dec_ready = 1'b0;
        step();
        tests++; if ({halted, imem_req} !== 2'b00) begin fails++; $display("FAIL halt_exit: got halted=%b req=%b want 0/0", halted, imem_req); end
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL halt_resume: got req=%b addr=%h want 1/0001", imem_req, imem_addr); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'hFFFF}) begin fails++; $display("FAIL wrap_reqffff: got req=%b addr=%h want 1/ffff", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = $urandom();
        step();
        imem_ack = 1'b0;
        tests++; if ({dec_valid, dec_pc} !== {1'b1, 16'hFFFF}) begin fails++; $display("FAIL wrap_decpc: got v=%b pc=%h want 1/ffff", dec_valid, dec_pc); end
        step();
        tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL wrap_req0: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        tests++; if ({imem_req, imem_addr, dec_valid, dec_insn, dec_pc, halted} !== 67'h0) begin fails++; $display("FAIL midreset_zero: got req=%b addr=%h v=%b insn=%h pc=%h halted=%b want all 0", imem_req, imem_addr, dec_valid, dec_insn, dec_pc, halted); end
        imem_ack = 1'b1; imem_data = 32'hCAFEF00D;
        step();
        rst = 1'b1;
        step();
        imem_ack = 1'b0;
        tests++; if ({imem_req, imem_addr, dec_valid, halted} !== {1'b1, 16'h0000, 1'b0, 1'b0}) begin fails++; $display("FAIL midreset_lateack: got req=%b addr=%h v=%b halted=%b want 1/0000/0/0", imem_req, imem_addr, dec_valid, halted); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            imem_ack    = ($urandom_range(0, 2) == 0);
            imem_data   = $urandom();
            dec_ready   = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom());
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            step();
            tests++; if (imem_req !== m_inflight) begin fails++; $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, m_inflight); end
            if (m_inflight) begin
                tests++; if (imem_addr !== m_addr) begin fails++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_addr); end
            end
            tests++; if (dec_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", i, dec_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                tests++; if ({dec_insn, dec_pc} !== {mq[0].insn, mq[0].pc}) begin fails++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", i, dec_insn, dec_pc, mq[0].insn, mq[0].pc); end
            end
            tests++; if (halted !== m_halted) begin fails++; $display("FAIL rnd_halted@%0d: got %b want %b", i, halted, m_halted); end
        end
        halt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
